// File: rtl/hdmi_tx_pkg.sv
// Shared types and constants for the HDMI transmit pixel path.
// Holds the pattern selector, the packed RGB pixel type and the colour-bar palette.
package hdmi_tx_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRID  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_WHITE   = 24'hFFFFFF;
    localparam rgb_t COL_YELLOW  = 24'hFFFF00;
    localparam rgb_t COL_CYAN    = 24'h00FFFF;
    localparam rgb_t COL_GREEN   = 24'h00FF00;
    localparam rgb_t COL_MAGENTA = 24'hFF00FF;
    localparam rgb_t COL_RED     = 24'hFF0000;
    localparam rgb_t COL_BLUE    = 24'h0000FF;
    localparam rgb_t COL_BLACK   = 24'h000000;

    // Bars run left to right in descending luminance order.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = COL_WHITE;
            3'd1:    bar_colour = COL_YELLOW;
            3'd2:    bar_colour = COL_CYAN;
            3'd3:    bar_colour = COL_GREEN;
            3'd4:    bar_colour = COL_MAGENTA;
            3'd5:    bar_colour = COL_RED;
            3'd6:    bar_colour = COL_BLUE;
            default: bar_colour = COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Stage-1 raster bundle: registered syncs, pixel position, frame count and
// the per-frame latched pattern settings, passed from the tracker to the colour stage.
interface test_pattern_gen_if #(
    parameter int XW = 10,
    parameter int YW = 9
) ();
    logic                 hs;
    logic                 vs;
    logic                 de;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [7:0]           frame;
    hdmi_tx_pkg::pattern_e pattern;
    hdmi_tx_pkg::rgb_t    solid;
    logic [2:0]           bar_idx;

    modport master (output hs, vs, de, x, y, frame, pattern, solid, bar_idx);
    modport slave  (input  hs, vs, de, x, y, frame, pattern, solid, bar_idx);
endinterface

// File: rtl/test_pattern_gen_raster_tracker.sv
// Stage 1: registers the timing-generator inputs, tracks x/y/frame/bar position,
// latches pattern settings at each vsync assertion and flags malformed rasters.
module raster_tracker
    import hdmi_tx_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int XW              = $clog2(H_ACTIVE),
    parameter int YW              = $clog2(V_ACTIVE)
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic               de_in,
    input  logic [1:0]         pattern_sel,
    input  rgb_t               solid_rgb,
    test_pattern_gen_if.master rt,
    output logic               timing_err
);
    localparam int   BAR_W     = H_ACTIVE / 8;
    localparam int   BW        = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int   RW        = $clog2(H_ACTIVE + 1) + 1;
    localparam int   LW        = $clog2(V_ACTIVE + 1) + 1;
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    frame_q, frame_d;
    pattern_e      pat_q, pat_d;
    rgb_t          solid_q, solid_d;
    logic [BW-1:0] bar_px_q, bar_px_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [RW-1:0] run_q, run_d;
    logic [LW-1:0] lines_q, lines_d, lines_inc;
    logic          seen_q, seen_d, err_q, err_d;
    logic          vs_edge, de_fall;

    always_comb begin
        vs_edge   = (v_sync_in != SYNC_IDLE) && (vs_q == SYNC_IDLE);
        de_fall   = de_q && !de_in;
        // Line count including a line that ends in this very cycle.
        lines_inc = (de_fall && lines_q != '1) ? lines_q + LW'(1) : lines_q;

        hs_d      = h_sync_in;
        vs_d      = v_sync_in;
        de_d      = de_in;
        x_d       = x_q;
        y_d       = y_q;
        frame_d   = frame_q;
        pat_d     = pat_q;
        solid_d   = solid_q;
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        run_d     = run_q;
        lines_d   = vs_edge ? '0 : lines_inc;
        seen_d    = seen_q | vs_edge;
        err_d     = err_q
                  | (de_fall && run_q != RW'(H_ACTIVE))
                  | (vs_edge && seen_q && lines_inc != LW'(V_ACTIVE));

        if (!de_in || !de_q) begin
            x_d       = '0;
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else begin
            if (x_q != XW'(H_ACTIVE - 1)) x_d = x_q + XW'(1);
            if (bar_px_q == BW'(BAR_W - 1)) begin
                bar_px_d = '0;
                if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + BW'(1);
            end
        end

        // Run length saturates well above H_ACTIVE so long lines still mismatch.
        if (!de_in)           run_d = '0;
        else if (!de_q)       run_d = RW'(1);
        else if (run_q != '1) run_d = run_q + RW'(1);

        if (vs_edge) begin
            y_d     = '0;
            frame_d = frame_q + 8'd1;
            pat_d   = pattern_e'(pattern_sel);
            solid_d = solid_rgb;
        end else if (de_fall && y_q != YW'(V_ACTIVE - 1)) begin
            y_d = y_q + YW'(1);
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            hs_q      <= SYNC_IDLE;
            vs_q      <= SYNC_IDLE;
            de_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= '0;
            pat_q     <= PAT_BARS;
            solid_q   <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            run_q     <= '0;
            lines_q   <= '0;
            seen_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            run_q     <= run_d;
            lines_q   <= lines_d;
            seen_q    <= seen_d;
            err_q     <= err_d;
        end
    end

    assign rt.hs      = hs_q;
    assign rt.vs      = vs_q;
    assign rt.de      = de_q;
    assign rt.x       = x_q;
    assign rt.y       = y_q;
    assign rt.frame   = frame_q;
    assign rt.pattern = pat_q;
    assign rt.solid   = solid_q;
    assign rt.bar_idx = bar_idx_q;
    assign timing_err = err_q;

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: raster tracking in stage 1, pattern mux and colour
// registers in stage 2, with syncs and data enable delay-matched to the pixels.
module test_pattern_gen
    import hdmi_tx_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        de_in,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        horz_sync,
    output logic        vert_sync,
    output logic        data_enable,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        timing_err
);
    localparam int   XW        = $clog2(H_ACTIVE);
    localparam int   YW        = $clog2(V_ACTIVE);
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    test_pattern_gen_if #(.XW(XW), .YW(YW)) rt ();

    raster_tracker #(
        .H_ACTIVE       (H_ACTIVE),
        .V_ACTIVE       (V_ACTIVE),
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW),
        .XW             (XW),
        .YW             (YW)
    ) u_tracker (
        .pixel_clock(pixel_clock),
        .reset      (reset),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .de_in      (de_in),
        .pattern_sel(pattern_sel),
        .solid_rgb  (rgb_t'(solid_rgb)),
        .rt         (rt),
        .timing_err (timing_err)
    );

    logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    rgb_t pix_q, pix_d;

    always_comb begin
        hs_d  = rt.hs;
        vs_d  = rt.vs;
        de_d  = rt.de;
        pix_d = COL_BLACK;
        case (rt.pattern)
            PAT_BARS: pix_d = bar_colour(rt.bar_idx);
            PAT_GRID: begin
                if ((rt.x & XW'(31)) == '0 || (rt.y & YW'(31)) == '0 ||
                    rt.x == XW'(H_ACTIVE - 1) || rt.y == YW'(V_ACTIVE - 1))
                    pix_d = COL_WHITE;
            end
            PAT_GRAD: begin
                pix_d.r = 8'(rt.x >> 2);
                pix_d.g = 8'(rt.y >> 1);
                pix_d.b = rt.frame;
            end
            default:  pix_d = rt.solid;
        endcase
        // Blanking always carries black so the transmitter never sees stray colour.
        if (!rt.de) pix_d = COL_BLACK;
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
            de_q  <= 1'b0;
            pix_q <= COL_BLACK;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            pix_q <= pix_d;
        end
    end

    assign horz_sync   = hs_q;
    assign vert_sync   = vs_q;
    assign data_enable = de_q;
    assign red         = pix_q.r;
    assign green       = pix_q.g;
    assign blue        = pix_q.b;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen on a reduced 64x32 raster: the driver
// pushes expectations from a count-based reference model, the monitor compares.
module tb_test_pattern_gen;
    import hdmi_tx_pkg::*;

    localparam int H  = 64;
    localparam int V  = 32;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h000000};
    localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    test_pattern_gen_if #(.XW(XW), .YW(YW)) stim ();

    logic       hs_o, vs_o, de_o, err_o;
    logic [7:0] r_o, g_o, b_o;

    test_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .pixel_clock(clk),
        .reset      (rst),
        .h_sync_in  (stim.hs),
        .v_sync_in  (stim.vs),
        .de_in      (stim.de),
        .pattern_sel(stim.pattern),
        .solid_rgb  (stim.solid),
        .horz_sync  (hs_o),
        .vert_sync  (vs_o),
        .data_enable(de_o),
        .red        (r_o),
        .green      (g_o),
        .blue       (b_o),
        .timing_err (err_o)
    );

    typedef struct { int due; logic [26:0] val; } vid_exp_t;
    typedef struct { int due; logic val; } err_exp_t;
    vid_exp_t vq[$];
    err_exp_t eq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int dcyc     = 0;
    int mcyc     = 0;
    bit rand_pat = 1'b0;
    bit after_rst;

    // Reference model state, expressed as plain counts of raster events.
    int          m_run, m_falls, m_frame;
    bit          m_prev_de, m_prev_vsa, m_seen, m_err;
    logic [1:0]  m_pat;
    logic [23:0] m_solid;

    function automatic logic [23:0] ref_colour(int x, int y, int fr, logic [1:0] pat, logic [23:0] solid);
        int idx;
        case (pat)
            2'd0: begin
                idx = x / (H / 8);
                if (idx > 7) idx = 7;
                return BAR_TAB[idx];
            end
            2'd1:    return (x % 32 == 0 || y % 32 == 0 || x == H - 1 || y == V - 1) ? 24'hFFFFFF : 24'h0;
            2'd2:    return {8'(x / 4), 8'(y / 2), 8'(fr)};
            default: return solid;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_falls = 0; m_frame = 0;
        m_prev_de = 0; m_prev_vsa = 0; m_seen = 0; m_err = 0;
        m_pat = 2'd0; m_solid = 24'h0;
    endtask

    task automatic model_step(input bit h, input bit v, input bit d);
        bit          vsa, fall, vs_edge;
        int          x, y;
        logic [23:0] c;
        vsa     = !v;
        fall    = m_prev_de && !d;
        vs_edge = vsa && !m_prev_vsa;
        if (fall) begin
            if (m_run != H) m_err = 1;
            m_falls++;
        end
        m_run = d ? (m_prev_de ? m_run + 1 : 1) : 0;
        if (vs_edge) begin
            if (m_seen && m_falls != V) m_err = 1;
            m_falls = 0;
            m_seen  = 1;
            m_frame = (m_frame + 1) % 256;
            m_pat   = stim.pattern;
            m_solid = stim.solid;
        end
        x = (m_run - 1 < H - 1) ? m_run - 1 : H - 1;
        y = (m_falls < V - 1) ? m_falls : V - 1;
        c = d ? ref_colour(x, y, m_frame, m_pat, m_solid) : 24'h0;
        vq.push_back('{due: dcyc + 2, val: {h, v, d, c}});
        eq.push_back('{due: dcyc + 1, val: m_err});
        m_prev_de  = d;
        m_prev_vsa = vsa;
    endtask

    task automatic cycle(input bit h, input bit v, input bit d, input bit r);
        @(posedge clk);
        #1;
        dcyc++;
        stim.hs = h; stim.vs = v; stim.de = d; rst = r;
        if (rand_pat && $urandom_range(0, 299) == 0) begin
            stim.pattern = pattern_e'($urandom_range(0, 3));
            stim.solid   = rgb_t'(24'($urandom));
        end
        if (r) begin
            while (vq.size() > 0 && vq[vq.size()-1].due >= dcyc + 1) vq.delete(vq.size() - 1);
            while (eq.size() > 0 && eq[eq.size()-1].due >= dcyc + 1) eq.delete(eq.size() - 1);
            vq.push_back('{due: dcyc + 1, val: IDLE});
            eq.push_back('{due: dcyc + 1, val: 1'b0});
            model_reset();
            after_rst = 1;
        end else begin
            if (after_rst) vq.push_back('{due: dcyc + 1, val: IDLE});
            after_rst = 0;
            model_step(h, v, d);
        end
    endtask

    task automatic line(input int act, input bit vs_on, input bit rst_in_fp);
        bit v;
        v = !vs_on;
        for (int i = 0; i < act; i++) cycle(1'b1, v, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)   cycle(1'b1, v, 1'b0, rst_in_fp && i == 1);
        for (int i = 0; i < 8; i++)   cycle(1'b0, v, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)   cycle(1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic frame(input int short_line, input int chg_line, input logic [1:0] chg_pat,
                         input logic [23:0] chg_rgb, input int rst_line);
        for (int l = 0; l < V; l++) begin
            if (l == chg_line) begin
                stim.pattern = pattern_e'(chg_pat);
                stim.solid   = rgb_t'(chg_rgb);
            end
            line((l == short_line) ? H - 1 : H, 1'b0, l == rst_line);
        end
        for (int l = 0; l < 6; l++) line(0, l >= 2 && l < 4, 1'b0);
    endtask

    task automatic set_pat(input logic [1:0] p, input logic [23:0] c);
        @(posedge clk);
        #1;
        stim.pattern = pattern_e'(p);
        stim.solid   = rgb_t'(c);
        dcyc++;
        model_step(stim.hs, stim.vs, stim.de);
    endtask

    // Monitor: compares every due expectation against the DUT outputs.
    initial begin
        vid_exp_t    ve;
        err_exp_t    ee;
        logic [26:0] act;
        forever begin
            @(posedge clk);
            mcyc++;
            #2;
            while (vq.size() > 0 && vq[0].due <= mcyc) begin
                ve = vq.pop_front();
                if (ve.due == mcyc) begin
                    act = {hs_o, vs_o, de_o, r_o, g_o, b_o};
                    n_checks++;
                    if (act !== ve.val) begin
                        n_fail++;
                        if (n_fail <= 30)
                            $display("FAIL video cyc=%0d actual hs/vs/de/rgb=%b/%b/%b/%06h required %b/%b/%b/%06h",
                                     mcyc, act[26], act[25], act[24], act[23:0],
                                     ve.val[26], ve.val[25], ve.val[24], ve.val[23:0]);
                    end
                end
            end
            while (eq.size() > 0 && eq[0].due <= mcyc) begin
                ee = eq.pop_front();
                if (ee.due == mcyc) begin
                    n_checks++;
                    if (err_o !== ee.val) begin
                        n_fail++;
                        if (n_fail <= 30)
                            $display("FAIL timing_err cyc=%0d actual %b required %b", mcyc, err_o, ee.val);
                    end
                end
            end
        end
    end

    initial begin
        stim.hs = 1'b1; stim.vs = 1'b1; stim.de = 1'b0;
        stim.pattern = PAT_BARS; stim.solid = '0;
        stim.x = '0; stim.y = '0; stim.frame = '0; stim.bar_idx = '0;
        model_reset();
        after_rst = 0;

        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        $display("phase: colour bars");
        frame(-1, -1, 2'd0, 24'h0, -1);
        frame(-1, -1, 2'd0, 24'h0, -1);

        $display("phase: gradient");
        set_pat(2'd2, 24'h0);
        repeat (3) frame(-1, -1, 2'd0, 24'h0, -1);

        $display("phase: mid-frame switch to solid 123456");
        set_pat(2'd0, 24'h0);
        frame(-1, 10, 2'd3, 24'h123456, -1);
        frame(-1, -1, 2'd0, 24'h0, -1);

        $display("phase: grid");
        set_pat(2'd1, 24'h0);
        frame(-1, -1, 2'd0, 24'h0, -1);
        frame(-1, -1, 2'd0, 24'h0, -1);

        $display("phase: short line");
        frame(5, -1, 2'd0, 24'h0, -1);

        $display("phase: reset mid-line");
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        line(0, 1'b0, 1'b0);
        frame(-1, -1, 2'd0, 24'h0, -1);

        $display("phase: reset in blanking mid-frame");
        frame(-1, -1, 2'd0, 24'h0, 10);
        frame(-1, -1, 2'd0, 24'h0, -1);

        $display("phase: random pattern changes");
        rand_pat = 1'b1;
        repeat (3) frame(-1, -1, 2'd0, 24'h0, -1);
        rand_pat = 1'b0;

        repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
